// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit controller and its datapath line mux.
// The STOP2 state exists only when UART_TX_CTRL_STOP2_EN is defined.
`timescale 1ns/1ps
package uart_tx_pkg;

    localparam logic [1:0] SEL_IDLE   = 2'd0;
    localparam logic [1:0] SEL_START  = 2'd1;
    localparam logic [1:0] SEL_PARITY = 2'd2;
    localparam logic [1:0] SEL_DATA   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
`ifdef UART_TX_CTRL_STOP2_EN
        ST_STOP,
        ST_STOP2
`else
        ST_STOP
`endif
    } tx_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// Control FSM for the UART Tx datapath: start, LSB-first data, optional parity, stop.
// Define UART_TX_CTRL_STOP2_EN to append a second stop bit (tx_done moves to its end).
`timescale 1ns/1ps
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_SIZE           = 8,
    parameter int unsigned SAMPLING_CNTR_WIDTH = 4,
    parameter int unsigned PARITY_ON           = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic [SAMPLING_CNTR_WIDTH-1:0] cfg_end_val,
    input  logic [SAMPLING_CNTR_WIDTH-1:0] sampling_cntr_out,
    input  logic [2:0]                     bits_cntr_out,
    output logic                           cntr_rst,
    output logic [SAMPLING_CNTR_WIDTH-1:0] sampling_end_val,
    output logic                           data_bits_incr,
    output logic                           data_w_en,
    output logic [1:0]                     select,
    output logic                           tx_busy,
    output logic                           tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_SIZE - 1);

`ifdef UART_TX_CTRL_STOP2_EN
    localparam tx_state_t ST_FINAL = ST_STOP2;
`else
    localparam tx_state_t ST_FINAL = ST_STOP;
`endif

    tx_state_t state;
    logic      tick;
    logic      last_bit;
    logic      in_idle;

    assign tick     = (sampling_cntr_out == sampling_end_val);
    assign last_bit = (bits_cntr_out == LAST_BIT);
    assign in_idle  = (state == ST_IDLE);

    // Only the handshake pair may follow tx_valid; everything else comes from state plus the datapath counters.
    assign tx_ready       = in_idle;
    assign data_w_en      = rst & in_idle & tx_valid;
    assign data_bits_incr = (state == ST_DATA) & tick & ~last_bit;
    assign tx_done        = (state == ST_FINAL) & tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_IDLE;
            select           <= SEL_IDLE;
            cntr_rst         <= 1'b1;
            tx_busy          <= 1'b0;
            sampling_end_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        sampling_end_val <= cfg_end_val;
                        state            <= ST_START;
                        select           <= SEL_START;
                        cntr_rst         <= 1'b0;
                        tx_busy          <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state  <= ST_DATA;
                        select <= SEL_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick && last_bit) begin
                        if (PARITY_ON != 0) begin
                            state  <= ST_PARITY;
                            select <= SEL_PARITY;
                        end else begin
                            state  <= ST_STOP;
                            select <= SEL_IDLE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state  <= ST_STOP;
                        select <= SEL_IDLE;
                    end
                end
`ifdef UART_TX_CTRL_STOP2_EN
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_STOP2;
                    end
                end
                ST_STOP2: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        cntr_rst <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                end
`else
                ST_STOP: begin
                    if (tick) begin
                        state    <= ST_IDLE;
                        cntr_rst <= 1'b1;
                        tx_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    select   <= SEL_IDLE;
                    cntr_rst <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural Tx datapath (counters, data register, line mux).
// Instance A uses the default parameters; instance B has PARITY_ON = 0.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
    import uart_tx_pkg::*;

    localparam int unsigned W = 4;
`ifdef UART_TX_CTRL_STOP2_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] tx_data;

    logic         a_valid, a_ready, a_cntr_rst, a_incr, a_wen, a_busy, a_done, a_line;
    logic [W-1:0] a_cfg, a_end, a_scnt;
    logic [2:0]   a_bcnt;
    logic [1:0]   a_sel;
    logic [7:0]   a_dreg;

    logic         b_valid, b_ready, b_cntr_rst, b_incr, b_wen, b_busy, b_done, b_line;
    logic [W-1:0] b_cfg, b_end, b_scnt;
    logic [2:0]   b_bcnt;
    logic [1:0]   b_sel;
    logic [7:0]   b_dreg;

    uart_tx_ctrl #(.DATA_SIZE(8), .SAMPLING_CNTR_WIDTH(W), .PARITY_ON(1)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(a_valid), .tx_ready(a_ready), .cfg_end_val(a_cfg),
        .sampling_cntr_out(a_scnt), .bits_cntr_out(a_bcnt), .cntr_rst(a_cntr_rst),
        .sampling_end_val(a_end), .data_bits_incr(a_incr), .data_w_en(a_wen),
        .select(a_sel), .tx_busy(a_busy), .tx_done(a_done)
    );

    uart_tx_ctrl #(.DATA_SIZE(8), .SAMPLING_CNTR_WIDTH(W), .PARITY_ON(0)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_ready(b_ready), .cfg_end_val(b_cfg),
        .sampling_cntr_out(b_scnt), .bits_cntr_out(b_bcnt), .cntr_rst(b_cntr_rst),
        .sampling_end_val(b_end), .data_bits_incr(b_incr), .data_w_en(b_wen),
        .select(b_sel), .tx_busy(b_busy), .tx_done(b_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_scnt <= '0; a_bcnt <= '0; a_dreg <= '0;
        end else begin
            if (a_cntr_rst) begin
                a_scnt <= '0; a_bcnt <= '0;
            end else begin
                a_scnt <= (a_scnt == a_end) ? '0 : a_scnt + W'(1);
                if (a_incr) a_bcnt <= a_bcnt + 3'd1;
            end
            if (a_wen) a_dreg <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            b_scnt <= '0; b_bcnt <= '0; b_dreg <= '0;
        end else begin
            if (b_cntr_rst) begin
                b_scnt <= '0; b_bcnt <= '0;
            end else begin
                b_scnt <= (b_scnt == b_end) ? '0 : b_scnt + W'(1);
                if (b_incr) b_bcnt <= b_bcnt + 3'd1;
            end
            if (b_wen) b_dreg <= tx_data;
        end
    end

    always_comb begin
        a_line = 1'b1;
        case (a_sel)
            SEL_START:  a_line = 1'b0;
            SEL_PARITY: a_line = ^a_dreg;
            SEL_DATA:   a_line = a_dreg[a_bcnt];
            default:    a_line = 1'b1;
        endcase
    end

    always_comb begin
        b_line = 1'b1;
        case (b_sel)
            SEL_START:  b_line = 1'b0;
            SEL_PARITY: b_line = ^b_dreg;
            SEL_DATA:   b_line = b_dreg[b_bcnt];
            default:    b_line = 1'b1;
        endcase
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        tests++; if (a_sel !== SEL_IDLE || b_sel !== SEL_IDLE) begin fails++; $display("FAIL reset_select: got %0d/%0d want 0", a_sel, b_sel); end
        tests++; if (a_cntr_rst !== 1'b1) begin fails++; $display("FAIL reset_cntr_rst: got %b want 1", a_cntr_rst); end
        tests++; if ({a_busy, a_done, a_incr, a_wen} !== 4'b0000) begin fails++; $display("FAIL reset_strobes: got %b want 0000", {a_busy, a_done, a_incr, a_wen}); end
        tests++; if (a_end !== 4'd0) begin fails++; $display("FAIL reset_end_val: got %0d want 0", a_end); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (a_sel !== SEL_IDLE || a_ready !== 1'b1 || a_busy !== 1'b0) begin fails++; $display("FAIL idle_after_reset: sel %0d ready %b busy %b want 0/1/0", a_sel, a_ready, a_busy); end
    endtask

    task automatic test_frame_parity;
        logic [10:0] exp_bits;
        logic        expb;
        int unsigned flen, b, line_err, busy_cnt, done_cyc, done_cnt, wen_cnt;
        logic        start_ok;
        exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        flen = (11 + EXTRA) * 16;
        line_err = 0; busy_cnt = 0; done_cyc = 0; done_cnt = 0; wen_cnt = 0; start_ok = 1'b0;
        a_cfg = 4'd15; tx_data = 8'hA5; a_valid = 1'b1;
        #1;
        tests++; if (a_wen !== 1'b1) begin fails++; $display("FAIL parity_accept_wen: got %b want 1", a_wen); end
        for (int unsigned c = 1; c <= flen + 1; c++) begin
            @(negedge clk);
            if (c == 1) start_ok = (a_sel === SEL_START) && (a_scnt === 4'd0);
            if (c <= flen) begin
                b = (c - 1) / 16;
                expb = (b < 11) ? exp_bits[b] : 1'b1;
                if (a_line !== expb) line_err++;
                if (a_busy === 1'b1) busy_cnt++;
            end
            if (a_done === 1'b1) begin
                if (done_cnt == 0) done_cyc = c;
                done_cnt++;
            end
            if (a_wen === 1'b1) wen_cnt++;
            if (c == 1) a_valid = 1'b0;
        end
        tests++; if (!start_ok) begin fails++; $display("FAIL parity_start_cycle1: start_ok %b want 1", start_ok); end
        tests++; if (line_err != 0) begin fails++; $display("FAIL parity_line: %0d wrong line cycles want 0", line_err); end
        tests++; if (done_cyc != flen || done_cnt != 1) begin fails++; $display("FAIL parity_done: cycle %0d count %0d want %0d/1", done_cyc, done_cnt, flen); end
        tests++; if (busy_cnt != flen) begin fails++; $display("FAIL parity_busy: %0d cycles want %0d", busy_cnt, flen); end
        tests++; if (a_busy !== 1'b0 || a_cntr_rst !== 1'b1 || wen_cnt != 0) begin fails++; $display("FAIL parity_return_idle: busy %b cntr_rst %b wen %0d want 0/1/0", a_busy, a_cntr_rst, wen_cnt); end
    endtask

    task automatic test_no_parity;
        logic [19:0] sel_seen, exp_sel;
        logic [9:0]  line_seen, exp_line;
        int unsigned flen, incr_cnt, done_cyc;
        exp_sel  = {2'd0, {8{2'd3}}, 2'd1};
        exp_line = {1'b1, 8'h3C, 1'b0};
        flen = 10 + EXTRA;
        sel_seen = '0; line_seen = '0; incr_cnt = 0; done_cyc = 0;
        b_cfg = 4'd0; tx_data = 8'h3C; b_valid = 1'b1;
        for (int unsigned c = 1; c <= flen + 1; c++) begin
            @(negedge clk);
            if (c <= 10) begin
                sel_seen[2*(c-1) +: 2] = b_sel;
                line_seen[c-1] = b_line;
            end
            if (b_incr === 1'b1) incr_cnt++;
            if (b_done === 1'b1 && done_cyc == 0) done_cyc = c;
            if (c == 1) b_valid = 1'b0;
        end
        tests++; if (sel_seen !== exp_sel) begin fails++; $display("FAIL noparity_select: got %h want %h", sel_seen, exp_sel); end
        tests++; if (line_seen !== exp_line) begin fails++; $display("FAIL noparity_line: got %b want %b", line_seen, exp_line); end
        tests++; if (incr_cnt != 7) begin fails++; $display("FAIL noparity_incr_count: got %0d want 7", incr_cnt); end
        tests++; if (done_cyc != flen) begin fails++; $display("FAIL noparity_done: cycle %0d want %0d", done_cyc, flen); end
    endtask

    task automatic test_back_to_back;
        int unsigned flen, last, wen_cnt, done_cnt, ready_cnt;
        int unsigned wen_pos[3];
        int unsigned done_pos[3];
        flen = (11 + EXTRA) * 4;
        last = 3 * flen + 2;
        wen_cnt = 0; done_cnt = 0; ready_cnt = 0;
        for (int i = 0; i < 3; i++) begin wen_pos[i] = 0; done_pos[i] = 0; end
        a_cfg = 4'd3; tx_data = 8'h96; a_valid = 1'b1;
        #1;
        if (a_wen === 1'b1) begin wen_pos[0] = 0; wen_cnt++; end
        for (int unsigned c = 1; c <= last + 2; c++) begin
            @(negedge clk);
            if (a_wen === 1'b1) begin
                if (wen_cnt < 3) wen_pos[wen_cnt] = c;
                wen_cnt++;
            end
            if (a_done === 1'b1) begin
                if (done_cnt < 3) done_pos[done_cnt] = c;
                done_cnt++;
            end
            if (c <= last && a_ready === 1'b1) ready_cnt++;
            if (c > 2 * (flen + 1)) a_valid = 1'b0;
        end
        tests++; if (wen_cnt != 3 || wen_pos[1] != flen + 1 || wen_pos[2] != 2 * flen + 2) begin fails++; $display("FAIL b2b_accepts: count %0d at %0d,%0d want 3 at %0d,%0d", wen_cnt, wen_pos[1], wen_pos[2], flen + 1, 2 * flen + 2); end
        tests++; if (done_cnt != 3 || done_pos[0] != flen || done_pos[1] != 2 * flen + 1 || done_pos[2] != last) begin fails++; $display("FAIL b2b_done: count %0d at %0d,%0d,%0d want 3 at %0d,%0d,%0d", done_cnt, done_pos[0], done_pos[1], done_pos[2], flen, 2 * flen + 1, last); end
        tests++; if (ready_cnt != 2) begin fails++; $display("FAIL b2b_idle_gap: %0d idle cycles want 2", ready_cnt); end
    endtask

    task automatic test_reset_mid_frame;
        int unsigned flen, done_cyc;
        logic        pre_ok, c1_ok, c5_ok;
        flen = (11 + EXTRA) * 4;
        done_cyc = 0; pre_ok = 1'b0; c1_ok = 1'b0; c5_ok = 1'b0;
        a_cfg = 4'd3; tx_data = 8'hA5; a_valid = 1'b1;
        for (int unsigned c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 1) a_valid = 1'b0;
        end
        pre_ok = (a_sel === SEL_DATA) && (a_bcnt === 3'd4);
        tests++; if (!pre_ok) begin fails++; $display("FAIL midrst_in_bit4: sel %0d bits %0d want 3/4", a_sel, a_bcnt); end
        rst = 1'b0;
        #1;
        tests++; if (a_sel !== SEL_IDLE || a_busy !== 1'b0 || a_ready !== 1'b1) begin fails++; $display("FAIL midrst_abort: sel %0d busy %b ready %b want 0/0/1", a_sel, a_busy, a_ready); end
        @(negedge clk);
        tests++; if (a_line !== 1'b1 || a_done !== 1'b0) begin fails++; $display("FAIL midrst_line: line %b done %b want 1/0", a_line, a_done); end
        rst = 1'b1;
        @(negedge clk);
        tx_data = 8'h5A; a_valid = 1'b1;
        for (int unsigned c = 1; c <= flen; c++) begin
            @(negedge clk);
            if (c == 1) c1_ok = (a_sel === SEL_START) && (a_bcnt === 3'd0) && (a_scnt === 4'd0);
            if (c == 5) c5_ok = (a_sel === SEL_DATA) && (a_bcnt === 3'd0) && (a_line === 1'b0);
            if (a_done === 1'b1 && done_cyc == 0) done_cyc = c;
            if (c == 1) a_valid = 1'b0;
        end
        tests++; if (!c1_ok || !c5_ok) begin fails++; $display("FAIL midrst_restart: cycle1 %b cycle5 %b want 1/1", c1_ok, c5_ok); end
        tests++; if (done_cyc != flen) begin fails++; $display("FAIL midrst_new_frame_done: cycle %0d want %0d", done_cyc, flen); end
    endtask

    task automatic test_cfg_change;
        int unsigned flen1, flen2, done1, done2;
        logic [W-1:0] mid_end1, mid_end2;
        flen1 = (11 + EXTRA) * 8;
        flen2 = (11 + EXTRA) * 3;
        done1 = 0; done2 = 0; mid_end1 = '0; mid_end2 = '0;
        a_cfg = 4'd7; tx_data = 8'h0F; a_valid = 1'b1;
        for (int unsigned c = 1; c <= flen1 + 1; c++) begin
            @(negedge clk);
            if (c == 50) mid_end1 = a_end;
            if (a_done === 1'b1 && done1 == 0) done1 = c;
            if (c == 1) begin a_valid = 1'b0; a_cfg = 4'd2; end
        end
        tests++; if (done1 != flen1 || mid_end1 !== 4'd7) begin fails++; $display("FAIL cfg_change_ignored: done %0d end %0d want %0d/7", done1, mid_end1, flen1); end
        a_valid = 1'b1;
        for (int unsigned c = 1; c <= flen2 + 1; c++) begin
            @(negedge clk);
            if (c == 10) mid_end2 = a_end;
            if (a_done === 1'b1 && done2 == 0) done2 = c;
            if (c == 1) a_valid = 1'b0;
        end
        tests++; if (done2 != flen2 || mid_end2 !== 4'd2) begin fails++; $display("FAIL cfg_next_frame: done %0d end %0d want %0d/2", done2, mid_end2, flen2); end
    endtask

`ifdef UART_TX_CTRL_STOP2_EN
    task automatic test_stop2;
        int unsigned run, stop_len, done_cyc;
        run = 0; stop_len = 0; done_cyc = 0;
        a_cfg = 4'd1; tx_data = 8'hA5; a_valid = 1'b1;
        for (int unsigned c = 1; c <= 26; c++) begin
            @(negedge clk);
            run = (a_line === 1'b1) ? run + 1 : 0;
            if (a_done === 1'b1 && done_cyc == 0) begin done_cyc = c; stop_len = run; end
            if (c == 1) a_valid = 1'b0;
        end
        tests++; if (done_cyc != 24) begin fails++; $display("FAIL stop2_done: cycle %0d want 24", done_cyc); end
        tests++; if (stop_len != 4) begin fails++; $display("FAIL stop2_stop_len: %0d cycles want 4", stop_len); end
    endtask
`endif

    initial begin
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_cfg = '0; b_cfg = '0; tx_data = '0;
        test_reset;
        test_frame_parity;
        test_no_parity;
        repeat (2) @(negedge clk);
        test_back_to_back;
        test_reset_mid_frame;
        repeat (2) @(negedge clk);
        test_cfg_change;
`ifdef UART_TX_CTRL_STOP2_EN
        repeat (2) @(negedge clk);
        test_stop2;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
